// File: rtl/button_debounce_pulse_if.sv
// rtl/button_debounce_pulse_if.sv - button level in, debounced level and rising-edge pulse out
interface button_debounce_pulse_if;
  logic i_btn;
  logic o_btn_deb;
  logic o_btn_pulse;

  modport master (
    output i_btn,
    input  o_btn_deb,
    input  o_btn_pulse
  );

  modport slave (
    input  i_btn,
    output o_btn_deb,
    output o_btn_pulse
  );
endinterface

// File: rtl/button_debounce_pulse.sv
// rtl/button_debounce_pulse.sv - synchronized, timed-FSM button debouncer with one-cycle press pulse
module button_debounce_pulse #(
  parameter int par_T_debounce_bits = 20,
  parameter int par_T_debounce_val  = 1000000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  button_debounce_pulse_if.slave   bus
);

  localparam logic [par_T_debounce_bits-1:0] c_tmax =
    par_T_debounce_bits'(par_T_debounce_val - 1);

  typedef enum logic [2:0] {
    ST_LOW       = 3'd0,
    ST_WAIT_HIGH = 3'd1,
    ST_PULSE     = 3'd2,
    ST_HIGH      = 3'd3,
    ST_WAIT_LOW  = 3'd4
  } state_t;

  state_t                         state_q;
  state_t                         state_d;
  logic                           meta_q;
  logic                           sync_q;
  logic [par_T_debounce_bits-1:0] timer_q;
  logic                           timer_done;
  logic                           deb;
  logic                           pulse;

  assign timer_done = (timer_q >= c_tmax);

  // Timer restarts on every state change so each wait state measures its own dwell.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      state_q <= ST_LOW;
      timer_q <= '0;
    end else begin
      meta_q  <= bus.i_btn;
      sync_q  <= meta_q;
      state_q <= state_d;
      if (state_d != state_q)
        timer_q <= '0;
      else if (!timer_done)
        timer_q <= timer_q + 1'b1;
    end
  end

  // Input reversal is tested before expiry in both wait states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOW:       if (sync_q) state_d = ST_WAIT_HIGH;
      ST_WAIT_HIGH: begin
        if (!sync_q)         state_d = ST_LOW;
        else if (timer_done) state_d = ST_PULSE;
      end
      ST_PULSE:     state_d = sync_q ? ST_HIGH : ST_WAIT_LOW;
      ST_HIGH:      if (!sync_q) state_d = ST_WAIT_LOW;
      ST_WAIT_LOW:  begin
        if (sync_q)          state_d = ST_HIGH;
        else if (timer_done) state_d = ST_LOW;
      end
      default:      state_d = ST_LOW;
    endcase
  end

  always_comb begin
    deb   = 1'b0;
    pulse = 1'b0;
    case (state_q)
      ST_PULSE: begin
        deb   = 1'b1;
        pulse = 1'b1;
      end
      ST_HIGH,
      ST_WAIT_LOW: deb = 1'b1;
      default: begin
        deb   = 1'b0;
        pulse = 1'b0;
      end
    endcase
  end

  assign bus.o_btn_deb   = deb;
  assign bus.o_btn_pulse = pulse;

endmodule
